// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
// one bit pair per clock, LSB first, one-cycle done pulse per result.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - load a, b, ci and begin an addition (IDLE or DONE only)
//   a, b  - WIDTH-bit operands, sampled on the accepting edge
//   ci    - initial carry-in, sampled on the accepting edge
//   busy  - high while the addition is in progress
//   done  - one-cycle pulse when s/co hold a new result
//   s, co - registered sum and carry-out of the last completed addition

module full_adder_one (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic co,
    output logic s
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_sum;
    logic [WIDTH-1:0]   r_s;
    logic               r_carry;
    logic               r_co;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_cell_s;
    logic               w_cell_co;
    logic [WIDTH-1:0]   w_sum_next;

    full_adder_one u_cell (
        .a  (r_opa[0]),
        .b  (r_opb[0]),
        .ci (r_carry),
        .co (w_cell_co),
        .s  (w_cell_s)
    );

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Sum register fills from the top so the LSB lands at bit 0 last.
    always_comb begin
        w_sum_next = r_sum >> 1;
        w_sum_next[WIDTH-1] = w_cell_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (start) w_state_next = RUN;
            RUN:  if (w_last) w_state_next = DONE;
            DONE: w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_co    <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= ci;
            r_cnt   <= '0;
            r_sum   <= '0;
        end else if (r_state == RUN) begin
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_carry <= w_cell_co;
            r_sum   <= w_sum_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_s  <= w_sum_next;
                r_co <= w_cell_co;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign s    = r_s;
    assign co   = r_co;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances)
// against a plain-arithmetic reference {co,s} = a + b + ci.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       ci;
    logic       busy, done, co;
    logic [7:0] s;

    logic       start1;
    logic [0:0] a1, b1, s1;
    logic       ci1, busy1, done1, co1;

    int vectors = 0;
    int errors  = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
        .busy(busy1), .done(done1), .s(s1), .co(co1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait for done with a bound; returns cycles waited and busy count.
    task automatic wait_done(output int cyc, output int nbusy,
                             output bit got, output bit hold_bad,
                             input logic [7:0] ps, input logic pco);
        cyc = 0; nbusy = 0; got = 0; hold_bad = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            if (done) got = 1;
            else begin
                if (busy) nbusy++;
                if (s !== ps || co !== pco) hold_bad = 1;
                tick();
                cyc++;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb,
                          input logic tci, input string tag);
        logic [8:0] exp;
        logic [7:0] ps;
        logic       pco;
        int cyc, nb;
        bit got, hb;
        exp = 9'(ta) + 9'(tb) + 9'(tci);
        ps = s; pco = co;
        a = ta; b = tb; ci = tci; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
        wait_done(cyc, nb, got, hb, ps, pco);
        check({tag, "_done"}, 32'(got), 32'd1);
        check({tag, "_busy8"}, nb, 8);
        check({tag, "_hold"}, 32'(hb), 32'd0);
        check({tag, "_sum"}, {23'd0, co, s}, {23'd0, exp});
        tick();
        check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int cyc, nb, t0, t1, ndone;
        bit got, hb;
        logic [8:0] exp;

        // Reset with start held: accepted on first edge after release
        rst = 1'b1; start = 1'b1; a = 8'h21; b = 8'h10; ci = 1'b1;
        start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
        tick(); tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_s", 32'(s), 0);
        check("rst_co", 32'(co), 0);
        #3 rst = 1'b0;
        tick();
        check("rel_start_busy", 32'(busy), 1);
        start = 1'b0;
        wait_done(cyc, nb, got, hb, 8'h00, 1'b0);
        check("rel_start_done", 32'(got), 1);
        check("rel_start_sum", {23'd0, co, s}, 32'h032);
        tick();

        // Directed cases
        run_op(8'h5A, 8'h3C, 1'b0, "t1");
        run_op(8'hFF, 8'h01, 1'b0, "t2a");
        run_op(8'hFF, 8'hFF, 1'b1, "t2b");

        // start during RUN is ignored
        a = 8'h12; b = 8'h34; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hAA; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_busy", 32'(busy), 1);
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                ndone++;
                check("t3_sum", {23'd0, co, s}, 32'h046);
            end
            tick();
        end
        check("t3_ndone", ndone, 1);

        // start held high: back-to-back additions
        a = 8'h01; b = 8'h01; ci = 1'b0; start = 1'b1;
        tick();
        a = 8'h80; b = 8'h80;
        wait_done(cyc, nb, got, hb, s, co);
        t0 = cyc;
        check("t4_done1", 32'(got), 1);
        check("t4_sum1", {23'd0, co, s}, 32'h002);
        tick();
        wait_done(cyc, nb, got, hb, s, co);
        t1 = cyc + 1;
        start = 1'b0;
        check("t4_done2", 32'(got), 1);
        check("t4_gap", t1, 9);
        check("t4_sum2", {23'd0, co, s}, 32'h100);
        check("t4_first", t0, 8);
        tick();
        check("t4_idle", 32'(busy), 0);

        // async reset mid-RUN
        run_op(8'h77, 8'h11, 1'b1, "t5pre");
        a = 8'h40; b = 8'h02; ci = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        #3 rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_s", 32'(s), 0);
        check("t5_co", 32'(co), 0);
        tick();
        #3 rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("t5_quiet", ndone, 0);
        run_op(8'h40, 8'h02, 1'b0, "t5post");

        // Randomised vectors
        for (int i = 0; i < 20; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), "rnd");

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); ci1 = 1'(i);
            exp = 9'(a1) + 9'(b1) + 9'(ci1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            check("w1_busy", 32'(busy1), 1);
            tick();
            check("w1_done", 32'(done1), 1);
            check("w1_sum", {30'd0, co1, s1}, 32'(exp));
            for (int k = 0; k < 8; k++) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
